// File: rtl/ro_pkg.sv
// Shared types and defaults for the ring-oscillator frequency counter.
// Holds the FSM state encoding and the default gate/settle timing.
package ro_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int COUNT_W_DEF    = 16;
   localparam int WINDOW_CYC_DEF = 1000;
   localparam int SETTLE_CYC_DEF = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ro_freq_counter_if.sv
// Control/result bundle between a measurement requester and the counter.
// The requester drives start; the counter returns status and the result.
interface ro_freq_counter_if
   import ro_pkg::*;
   #(parameter int COUNT_W = COUNT_W_DEF) ();

   logic               start;
   logic               busy;
   logic               done;
   logic [COUNT_W-1:0] count;
   logic               overflow;

   modport master (
      output start,
      input  busy,
      input  done,
      input  count,
      input  overflow
   );

   modport slave (
      input  start,
      output busy,
      output done,
      output count,
      output overflow
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ro_freq_counter.sv
// Gated edge counter for a ring oscillator: enable, settle, count
// rising edges over a fixed clk window, then report once.
module ro_freq_counter
   import ro_pkg::*;
   #(
      parameter int COUNT_W    = COUNT_W_DEF,
      parameter int WINDOW_CYC = WINDOW_CYC_DEF,
      parameter int SETTLE_CYC = SETTLE_CYC_DEF
   ) (
      input  logic            clk,
      input  logic            rst_n,
      input  logic            ro_in,
      output logic            ro_enable,
      ro_freq_counter_if.slave bus
   );

   localparam int TMR_MAX = max2(SETTLE_CYC, WINDOW_CYC);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYC - 1);

   state_t             state;
   logic [TMR_W-1:0]   tmr;
   logic               tmr_zero;
   logic [COUNT_W-1:0] cnt;
   logic [COUNT_W-1:0] cnt_nxt;
   logic               ovf;
   logic               ovf_nxt;
   logic               ro_s;
   logic               ro_d;
   logic               ro_rise;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ro_in),
      .q     (ro_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ro_d <= 1'b0;
      else        ro_d <= ro_s;
   end

   assign ro_rise  = ro_s & ~ro_d;
   assign tmr_zero = (tmr == '0);

   // Saturate at all-ones; an edge that cannot be counted flags overflow.
   always_comb begin
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (state == COUNT && ro_rise) begin
         if (&cnt) ovf_nxt = 1'b1;
         else      cnt_nxt = cnt + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tmr          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         ro_enable    <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.count    <= '0;
         bus.overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= SETTLE;
                  tmr       <= SETTLE_LD;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  ro_enable <= 1'b1;
                  bus.busy  <= 1'b1;
               end
            end
            SETTLE: begin
               if (tmr_zero) begin
                  state <= COUNT;
                  tmr   <= WINDOW_LD;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            COUNT: begin
               cnt <= cnt_nxt;
               ovf <= ovf_nxt;
               // Capture next-state values so the last window cycle counts.
               if (tmr_zero) begin
                  state        <= DONE;
                  ro_enable    <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.count    <= cnt_nxt;
                  bus.overflow <= ovf_nxt;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: directed runs with a timeline/edge-count
// model checked every cycle, plus literal expectations per run.
module tb_ro_freq_counter;
   import ro_pkg::*;

   localparam int SET = 8;
   localparam int WIN = 1000;
   localparam int LAT = SET + WIN + 1;
   localparam int NH  = 16384;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ro0   = 1'b0;
   logic ro1   = 1'b0;
   logic en0;
   logic en1;

   ro_freq_counter_if #(.COUNT_W(16)) b0 ();
   ro_freq_counter_if #(.COUNT_W(4))  b1 ();

   ro_freq_counter #(
      .COUNT_W(16), .WINDOW_CYC(WIN), .SETTLE_CYC(SET)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .ro_in(ro0),
      .ro_enable(en0), .bus(b0.slave)
   );

   ro_freq_counter #(
      .COUNT_W(4), .WINDOW_CYC(WIN), .SETTLE_CYC(SET)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .ro_in(ro1),
      .ro_enable(en1), .bus(b1.slave)
   );

   always #5 clk = ~clk;

   // 0: free-running, 1: gated by ro_enable, 2: held low
   int osc_mode = 0;

   initial begin
      #3;
      forever begin
         #250;
         if (osc_mode == 2)                      ro0 = 1'b0;
         else if (osc_mode == 0 || en0 == 1'b1)  ro0 = ~ro0;
      end
   end

   initial begin
      #3;
      forever begin
         #30;
         ro1 = ~ro1;
      end
   end

   bit hist [2][NH];
   int cyc = 0;

   always @(posedge clk) begin
      if (cyc < NH) begin
         hist[0][cyc] <= ro0;
         hist[1][cyc] <= ro1;
      end
      cyc <= cyc + 1;
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint act,
                        input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input longint act,
                            input longint lo, input longint hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d..%0d",
                  name, act, lo, hi);
      end
   endtask

   // Rising edges of the twice-registered input seen during the window.
   function automatic int model_edges(input int i, input int s);
      int e = 0;
      for (int n = s + SET; n < s + SET + WIN; n++)
         if (hist[i][n-1] && !hist[i][n-2]) e++;
      return e;
   endfunction

   bit act      [2];
   int s_edge   [2];
   int held_cnt [2];
   bit held_ovf [2];

   always @(negedge clk) begin : cmp
      int n, k, e, mx, a_cnt;
      bit was_idle, st, e_en, e_busy, e_done;
      bit a_en, a_busy, a_done, a_ovf;
      n = cyc - 1;
      for (int i = 0; i < 2; i++) begin
         mx     = (i == 0) ? 65535 : 15;
         a_en   = (i == 0) ? en0 : en1;
         a_busy = (i == 0) ? b0.busy : b1.busy;
         a_done = (i == 0) ? b0.done : b1.done;
         a_ovf  = (i == 0) ? b0.overflow : b1.overflow;
         a_cnt  = (i == 0) ? int'(b0.count) : int'(b1.count);
         st     = (i == 0) ? b0.start : b1.start;
         e_en   = 1'b0;
         e_busy = 1'b0;
         e_done = 1'b0;
         k      = 0;
         if (!rst_n) begin
            act[i]      = 1'b0;
            held_cnt[i] = 0;
            held_ovf[i] = 1'b0;
         end
         was_idle = !act[i];
         if (rst_n && act[i]) begin
            k      = n - s_edge[i];
            e_en   = (k < SET + WIN);
            e_busy = 1'b1;
            e_done = (k == SET + WIN);
            if (e_done) begin
               e = model_edges(i, s_edge[i]);
               held_cnt[i] = (e > mx) ? mx : e;
               held_ovf[i] = (e > mx);
            end
         end
         check($sformatf("u%0d.ro_enable@%0d", i, n), a_en, e_en);
         check($sformatf("u%0d.busy@%0d", i, n), a_busy, e_busy);
         check($sformatf("u%0d.done@%0d", i, n), a_done, e_done);
         check($sformatf("u%0d.count@%0d", i, n), a_cnt, held_cnt[i]);
         check($sformatf("u%0d.overflow@%0d", i, n), a_ovf, held_ovf[i]);
         if (e_done) act[i] = 1'b0;
         if (rst_n && st && was_idle) begin
            act[i]    = 1'b1;
            s_edge[i] = n + 1;
         end
      end
   end

   task automatic set_start(input int i, input logic v);
      if (i == 0) b0.start = v;
      else        b1.start = v;
   endtask

   // One start pulse, optional extra start pulses and a reset pulse,
   // observed for a bounded number of cycles.
   task automatic run(input int i, input int r1, input int r2,
                      input int rst_at, input int budget,
                      output int first, output int ndone,
                      output int cnt, output int ovf, output int anyout);
      logic d;
      first  = -1;
      ndone  = 0;
      cnt    = -1;
      ovf    = -1;
      anyout = -1;
      set_start(i, 1'b1);
      for (int lat = 1; lat <= budget; lat++) begin
         @(posedge clk);
         #1;
         set_start(i, 1'b0);
         d = (i == 0) ? b0.done : b1.done;
         if (d) begin
            ndone++;
            if (first < 0) begin
               first = lat;
               cnt = (i == 0) ? int'(b0.count) : int'(b1.count);
               ovf = (i == 0) ? int'(b0.overflow) : int'(b1.overflow);
            end
         end
         if (lat == rst_at + 1)
            anyout = int'(en0) + int'(b0.busy) + int'(b0.done)
                   + int'(b0.count) + int'(b0.overflow);
         if (lat == r1 || lat == r2) set_start(i, 1'b1);
         if (lat == rst_at)     rst_n = 1'b0;
         if (lat == rst_at + 3) rst_n = 1'b1;
      end
   endtask

   int first, ndone, cnt, ovf, anyout, base;
   logic rv;

   initial begin
      b0.start = 1'b0;
      b1.start = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.count", b0.count, 0);
      check("reset.busy", b0.busy, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run(0, -1, -1, -1, 1100, first, ndone, cnt, ovf, anyout);
      check("basic.latency", first, LAT);
      check("basic.ndone", ndone, 1);
      check_rng("basic.count", cnt, 19, 21);
      check("basic.overflow", ovf, 0);
      check("basic.idle_en", en0, 0);
      base = cnt;

      osc_mode = 1;
      run(0, -1, -1, -1, 1100, first, ndone, cnt, ovf, anyout);
      check("loop.latency", first, LAT);
      check_rng("loop.count", cnt, 19, 21);
      rv = ro0;
      repeat (300) @(posedge clk);
      #1;
      check("loop.ro_static", ro0, rv);

      osc_mode = 0;
      run(0, SET + 101, LAT, -1, 1300, first, ndone, cnt, ovf, anyout);
      check("ignore.latency", first, LAT);
      check("ignore.ndone", ndone, 1);
      check_rng("ignore.count", cnt, base - 1, base + 1);
      check("ignore.busy_end", b0.busy, 0);

      run(0, -1, -1, 500, 1100, first, ndone, cnt, ovf, anyout);
      check("rst.ndone", ndone, 0);
      check("rst.outs_zero", anyout, 0);
      check("rst.count_after", b0.count, 0);
      check("rst.en_after", en0, 0);
      repeat (3) @(posedge clk);
      #1;
      run(0, -1, -1, -1, 1100, first, ndone, cnt, ovf, anyout);
      check("rst.rerun_latency", first, LAT);
      check_rng("rst.rerun_count", cnt, 19, 21);

      osc_mode = 2;
      ro0 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      run(0, -1, -1, -1, 1100, first, ndone, cnt, ovf, anyout);
      check("static.latency", first, LAT);
      check("static.count", cnt, 0);
      check("static.overflow", ovf, 0);

      run(1, -1, -1, -1, 1100, first, ndone, cnt, ovf, anyout);
      check("sat.latency", first, LAT);
      check("sat.count", cnt, 15);
      check("sat.overflow", ovf, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameter COUNT_W, default 16: width of the edge count result.
REQ-002 Parameter WINDOW_CYC, default 1000: gate window length in clk cycles.
REQ-003 Parameter SETTLE_CYC, default 8: cycles between enabling the oscillator and opening the gate.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a measurement; sampled only in IDLE.
REQ-007 ro_in  input  1  oscillator output, asynchronous to clk.
REQ-008 ro_enable  output  1  drives the oscillator Enable input.
REQ-009 busy  output  1  high in SETTLE, COUNT and DONE.
REQ-010 done  output  1  one-cycle pulse when count is valid.
REQ-011 count  output  COUNT_W  rising edges of ro_in seen in the last gate window.
REQ-012 overflow  output  1  count saturated during the last window.

Function
REQ-013 ro_in SHALL pass through a 2-flop synchronizer; a rising edge is detected when sync output is 1 and its one-cycle-delayed copy is 0.
REQ-014 States SHALL be IDLE, SETTLE, COUNT, DONE.
REQ-015 IDLE: start=1 -> SETTLE next cycle; edge counter, overflow and window timer cleared on that transition.
REQ-016 SETTLE: ro_enable=1; detected edges ignored; after exactly SETTLE_CYC cycles -> COUNT.
REQ-017 COUNT: ro_enable=1; each detected edge increments the edge counter by 1; after exactly WINDOW_CYC cycles -> DONE.
REQ-018 Edges detected in any of the WINDOW_CYC COUNT cycles SHALL be counted; edges in SETTLE or DONE SHALL NOT.
REQ-019 At all-ones the counter SHALL hold and set overflow; overflow stays 1 until the next start.
REQ-020 DONE: lasts one cycle; done=1, ro_enable=0, count/overflow registered from the counter; -> IDLE.
REQ-021 Total latency start accepted -> done pulse SHALL be SETTLE_CYC + WINDOW_CYC + 1 cycles.
REQ-022 count and overflow SHALL hold their values from DONE until the next DONE.
REQ-023 start while busy=1 (including in DONE) SHALL be ignored, not queued.
REQ-024 ro_enable SHALL be 0 in IDLE and DONE.
REQ-025 Correct counting requires each ro_in level to last >= 2 clk cycles; faster inputs are out of scope (under-count allowed, no lockup).

Reset
REQ-026 On rst_n=0, regardless of state: state=IDLE; ro_enable, busy, done, overflow=0; count=0; synchronizer flops=0; timers cleared.
REQ-027 Reset asserted mid-SETTLE or mid-COUNT SHALL abort the measurement with no done pulse; oscillator disabled immediately.

Structure
REQ-028 State enum and default parameter values SHALL live in shared package ro_pkg.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (async active-low reset to 0), instantiated once.
REQ-030 Window and settle timing SHALL share one down-counter sized for max(SETTLE_CYC, WINDOW_CYC).

Verification
REQ-031 Basic: clk 10 ns, ro_in half-period 250 ns, WINDOW_CYC=1000, start pulse -> done 1009 cycles after start, count 20 +/-1, overflow=0.
REQ-032 Loop to oscillator model: ro_enable driving the oscillator Enable -> oscillator toggles only while busy, count 20 +/-1; ro_in static after DONE.
REQ-033 Saturation: COUNT_W=4, ro_in half-period 30 ns (3 clk cycles), WINDOW_CYC=1000 -> count=15, overflow=1.
REQ-034 Ignored start: second start pulse 100 cycles into COUNT -> exactly one done pulse, result equal to single-start run.
REQ-035 Reset mid-COUNT: rst_n low 3 cycles at cycle 500 -> no done, all outputs 0; next start gives a full valid result.
REQ-036 Static input: ro_in held 0 -> count=0, overflow=0, done still after 1009 cycles.
